// File: rtl/alu_regfile_seq.sv
// rtl/alu_regfile_seq.sv - register file with a three-state sequential ALU (IDLE/EXEC/WB)
// Optional feature macro: ALU_REGFILE_SEQ_MUL_EN turns op F into an unsigned multiply.
module alu_regfile_seq #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic                     load,
    input  logic                     cin,
    input  logic [3:0]               op,
    input  logic [$clog2(NREGS)-1:0] sel_a,
    input  logic [$clog2(NREGS)-1:0] sel_b,
    input  logic [$clog2(NREGS)-1:0] sel_d,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ready,
    output logic [DATA_W-1:0]        data_out,
    output logic [3:0]               flags,
    output logic                     done,
    output logic                     err
);

    localparam int AW  = $clog2(NREGS);
    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_PASS = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [3:0]        op_q;
    logic [AW-1:0]     dst_q;
    logic              cin_q;

    logic [DATA_W-1:0] res;
    logic              c_f;
    logic              v_f;
    logic              illegal;
    logic              write_back;
    logic              carry_add;
    logic              borrow_sub;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   inc;
`ifdef ALU_REGFILE_SEQ_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    assign ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (valid_in && !load) state_nx = S_EXEC;
            S_EXEC: state_nx = S_WB;
            S_WB:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Carry-in only participates for the with-carry variants.
    always_comb begin
        carry_add  = (op_q == OP_ADC) ? cin_q : 1'b0;
        borrow_sub = (op_q == OP_SBC) ? cin_q : 1'b0;
        sum  = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, carry_add};
        diff = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, borrow_sub};
        inc  = {1'b0, a_q} + {{DATA_W{1'b0}}, 1'b1};
    end

`ifdef ALU_REGFILE_SEQ_MUL_EN
    assign prod = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
`endif

    always_comb begin
        res        = a_q;
        c_f        = 1'b0;
        v_f        = 1'b0;
        illegal    = 1'b0;
        write_back = 1'b1;
        case (op_q)
            OP_ADD, OP_ADC: begin
                res = sum[MSB:0];
                c_f = sum[DATA_W];
                v_f = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                res = diff[MSB:0];
                c_f = diff[DATA_W];
                v_f = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
                write_back = (op_q != OP_CMP);
            end
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_NOT:  res = ~a_q;
            OP_SHL: begin
                res = {a_q[MSB-1:0], 1'b0};
                c_f = a_q[MSB];
            end
            OP_SHR: begin
                res = {1'b0, a_q[MSB:1]};
                c_f = a_q[0];
            end
            OP_ROL: begin
                res = {a_q[MSB-1:0], a_q[MSB]};
                c_f = a_q[MSB];
            end
            OP_ROR: begin
                res = {a_q[0], a_q[MSB:1]};
                c_f = a_q[0];
            end
            OP_PASS: res = a_q;
            OP_INC: begin
                res = inc[MSB:0];
                c_f = inc[DATA_W];
                v_f = !a_q[MSB] && inc[MSB];
            end
            default: begin
`ifdef ALU_REGFILE_SEQ_MUL_EN
                res = prod[MSB:0];
                c_f = |prod[2*DATA_W-1:DATA_W];
`else
                illegal    = 1'b1;
                write_back = 1'b0;
`endif
            end
        endcase
    end

    // CMP and illegal ops leave data_out alone; CMP still updates flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            cin_q    <= 1'b0;
            data_out <= '0;
            flags    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (load) begin
                            regs[sel_d] <= data_in;
                        end else begin
                            a_q   <= regs[sel_a];
                            b_q   <= regs[sel_b];
                            op_q  <= op;
                            dst_q <= sel_d;
                            cin_q <= cin;
                        end
                    end
                end
                S_EXEC: begin
                    if (!illegal) begin
                        if (op_q != OP_CMP) begin
                            data_out <= res;
                        end
                        flags <= {c_f, (res == '0), res[MSB], v_f};
                    end
                end
                S_WB: begin
                    if (write_back) begin
                        regs[dst_q] <= data_out;
                    end
                    done <= 1'b1;
                    err  <= illegal;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// tb/tb_alu_regfile_seq.sv - directed scoreboard bench for alu_regfile_seq
module tb_alu_regfile_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       load = 1'b0;
    logic       cin = 1'b0;
    logic [3:0] op = 4'h0;
    logic [2:0] sel_a = 3'd0;
    logic [2:0] sel_b = 3'd0;
    logic [2:0] sel_d = 3'd0;
    logic [7:0] data_in = 8'h00;
    logic       ready;
    logic [7:0] data_out;
    logic [3:0] flags;
    logic       done;
    logic       err;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    string      q_tag [$];
    logic [7:0] q_data [$];
    logic [3:0] q_flags [$];
    logic       q_err [$];
    bit         q_chk [$];

    alu_regfile_seq #(.DATA_W(8), .NREGS(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .load(load), .cin(cin),
        .op(op), .sel_a(sel_a), .sel_b(sel_b), .sel_d(sel_d), .data_in(data_in),
        .ready(ready), .data_out(data_out), .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_reg(input int r, input logic [7:0] v);
        @(negedge clk);
        valid_in = 1'b1; load = 1'b1; sel_d = 3'(r); data_in = v;
        @(negedge clk);
        valid_in = 1'b0; load = 1'b0;
    endtask

    // Pushes the expectation, issues the op, waits for done and compares.
    task automatic run_op(input string tag, input logic [3:0] o, input int a, input int b,
                          input int d, input logic c, input logic [7:0] ed,
                          input logic [3:0] ef, input logic ee, input bit chk, input bit hold);
        int cyc;
        string t;
        logic [7:0] xd;
        logic [3:0] xf;
        logic       xe;
        bit         xc;
        q_tag.push_back(tag); q_data.push_back(ed); q_flags.push_back(ef);
        q_err.push_back(ee); q_chk.push_back(chk);
        @(negedge clk);
        valid_in = 1'b1; load = 1'b0; op = o; cin = c;
        sel_a = 3'(a); sel_b = 3'(b); sel_d = 3'(d);
        @(negedge clk);
        check({tag, "_busy"}, 32'(ready), 32'd0);
        if (hold) begin
            load = 1'b1; sel_d = 3'd4; data_in = 8'h55;
        end else begin
            valid_in = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        valid_in = 1'b0; load = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd2);
        t = q_tag.pop_front(); xd = q_data.pop_front(); xf = q_flags.pop_front();
        xe = q_err.pop_front(); xc = q_chk.pop_front();
        if (xc) check({t, "_data"}, 32'(data_out), 32'(xd));
        check({t, "_flags"}, 32'(flags), 32'(xf));
        check({t, "_err"}, 32'(err), 32'(xe));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        load_reg(1, 8'h05);
        load_reg(2, 8'h03);
        run_op("add_basic", 4'h0, 1, 2, 3, 1'b0, 8'h08, 4'b0000, 1'b0, 1'b1, 1'b0);
        run_op("pass_r3", 4'hC, 3, 3, 3, 1'b0, 8'h08, 4'b0000, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg", 4'h2, 2, 1, 5, 1'b0, 8'hFE, 4'b1010, 1'b0, 1'b1, 1'b0);

        load_reg(6, 8'h7F);
        load_reg(7, 8'h01);
        run_op("add_ovf", 4'h0, 6, 7, 0, 1'b0, 8'h80, 4'b0011, 1'b0, 1'b1, 1'b0);
        load_reg(6, 8'hFF);
        run_op("add_wrap", 4'h0, 6, 7, 0, 1'b0, 8'h00, 4'b1100, 1'b0, 1'b1, 1'b0);
        run_op("inc_wrap", 4'hE, 6, 6, 5, 1'b0, 8'h00, 4'b1100, 1'b0, 1'b1, 1'b0);

        load_reg(4, 8'hAA);
        load_reg(6, 8'h05);
        load_reg(7, 8'h05);
        run_op("cmp_eq", 4'hD, 6, 7, 4, 1'b0, 8'h00, 4'b0100, 1'b0, 1'b0, 1'b1);
        run_op("cmp_r4", 4'hC, 4, 4, 4, 1'b0, 8'hAA, 4'b0010, 1'b0, 1'b1, 1'b0);

        load_reg(1, 8'hF0);
        load_reg(2, 8'h0F);
        run_op("and", 4'h4, 1, 2, 5, 1'b0, 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
        run_op("or", 4'h5, 1, 2, 5, 1'b0, 8'hFF, 4'b0010, 1'b0, 1'b1, 1'b0);
        run_op("xor", 4'h6, 1, 2, 5, 1'b0, 8'hFF, 4'b0010, 1'b0, 1'b1, 1'b0);
        run_op("not", 4'h7, 1, 2, 5, 1'b0, 8'h0F, 4'b0000, 1'b0, 1'b1, 1'b0);
        run_op("adc", 4'h1, 1, 2, 5, 1'b1, 8'h00, 4'b1100, 1'b0, 1'b1, 1'b0);
        run_op("sbc", 4'h3, 1, 2, 5, 1'b1, 8'hE0, 4'b0010, 1'b0, 1'b1, 1'b0);
        run_op("shl", 4'h8, 1, 2, 5, 1'b0, 8'hE0, 4'b1010, 1'b0, 1'b1, 1'b0);
        run_op("shr", 4'h9, 2, 1, 5, 1'b0, 8'h07, 4'b1000, 1'b0, 1'b1, 1'b0);
        run_op("ror", 4'hB, 2, 1, 5, 1'b0, 8'h87, 4'b1010, 1'b0, 1'b1, 1'b0);
        run_op("rol", 4'hA, 1, 2, 5, 1'b0, 8'hE1, 4'b1010, 1'b0, 1'b1, 1'b0);

        load_reg(1, 8'h10);
        load_reg(2, 8'h10);
        load_reg(5, 8'h33);
        run_op("pass_r5", 4'hC, 5, 5, 5, 1'b0, 8'h33, 4'b0000, 1'b0, 1'b1, 1'b0);
`ifdef ALU_REGFILE_SEQ_MUL_EN
        run_op("mul", 4'hF, 1, 2, 5, 1'b0, 8'h00, 4'b1100, 1'b0, 1'b1, 1'b0);
        run_op("mul_r5", 4'hC, 5, 5, 5, 1'b0, 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
`else
        run_op("illegal", 4'hF, 1, 2, 5, 1'b0, 8'h33, 4'b0000, 1'b1, 1'b1, 1'b0);
        run_op("illegal_r5", 4'hC, 5, 5, 5, 1'b0, 8'h33, 4'b0000, 1'b0, 1'b1, 1'b0);
`endif

        @(negedge clk);
        valid_in = 1'b1; load = 1'b0; op = 4'h0; sel_a = 3'd1; sel_b = 3'd2; sel_d = 3'd3;
        @(negedge clk);
        valid_in = 1'b0;
        check("abort_busy", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (cyc = 0; cyc < 5; cyc++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        for (int r = 0; r < 8; r++) begin
            run_op($sformatf("zero_r%0d", r), 4'hC, r, r, r, 1'b0, 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
        end
        check("sb_empty", 32'(q_tag.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
